// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves value by at most one step's worth
// of bits, left (zero fill) or right (zero or sign fill).
module alu_shift_step #(
  parameter int XLEN  = 64,
  parameter int AMT_W = 4
) (
  input  logic [XLEN-1:0]  value,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir_right,
  input  logic             arith,
  output logic [XLEN-1:0]  shifted
);

  // Select shift direction and fill for this step.
  always_comb begin
    shifted = value;
    if (!dir_right) begin
      shifted = value << amount;
    end else if (arith) begin
      shifted = $signed(value) >>> amount;
    end else begin
      shifted = value >> amount;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU. Arithmetic/logic ops complete in one cycle; shifts walk
// through RUN moving at most SHIFT_STEP bits per cycle.
//
// state | meaning
// IDLE  | empty, ready to accept
// RUN   | shift in progress, input stalled
// DONE  | result presented, waiting for out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            overflow,
  output logic            zero,
  output logic            illegal
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int STEP_W  = $clog2(SHIFT_STEP + 1);

  if ((SHIFT_STEP < 1) || ((SHIFT_STEP & (SHIFT_STEP - 1)) != 0) || (SHIFT_STEP > XLEN))
  begin : g_bad_step
    $error("alu_mc: SHIFT_STEP must be a power of two in 1..XLEN");
  end

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("alu_mc: XLEN must be 32 or 64");
  end

  state_e state_q, state_d;

  logic               accept;
  logic               start_run;
  logic [SHAMT_W-1:0] shamt;

  logic [XLEN-1:0]    work_q;
  logic [SHAMT_W-1:0] rem_q;
  logic               dir_right_q;
  logic               arith_q;
  logic [31:0]        rem_ext;
  logic [STEP_W-1:0]  step_amt;
  logic               last_step;
  logic [XLEN-1:0]    step_out;

  logic [XLEN-1:0]    b_eff;
  logic               sub;
  logic [XLEN:0]      sum_ext;
  logic [XLEN-1:0]    alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_zero;
  logic               alu_illegal;

  logic [XLEN-1:0]    result_q;
  logic               carry_q;
  logic               overflow_q;
  logic               zero_q;
  logic               illegal_q;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready && !flush;

  assign shamt     = b[SHAMT_W-1:0];
  assign start_run = is_shift_op(op) && (shamt != '0);

  // Each RUN cycle consumes min(SHIFT_STEP, remaining) bits of the shift.
  assign rem_ext   = 32'(rem_q);
  assign step_amt  = (rem_ext >= 32'(SHIFT_STEP)) ? STEP_W'(SHIFT_STEP) : STEP_W'(rem_q);
  assign last_step = (rem_ext <= 32'(SHIFT_STEP));

  alu_shift_step #(
    .XLEN  (XLEN),
    .AMT_W (STEP_W)
  ) u_shift_step (
    .value     (work_q),
    .amount    (step_amt),
    .dir_right (dir_right_q),
    .arith     (arith_q),
    .shifted   (step_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accept overrides the DONE->IDLE drain, flush overrides all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = start_run ? ST_RUN : ST_DONE;
    end
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // Single-cycle arithmetic, compare and logic results from the live operands.
  always_comb begin
    b_eff       = b;
    sub         = 1'b0;
    sum_ext     = '0;
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sub       = (op == OP_SUB);
        b_eff     = sub ? ~b : b;
        sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
        alu_res   = sum_ext[XLEN-1:0];
        alu_carry = sum_ext[XLEN];
        alu_ovf   = (a[XLEN-1] == b_eff[XLEN-1]) && (alu_res[XLEN-1] != a[XLEN-1]);
      end
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // Only zero-amount shifts complete here; others go through RUN.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_illegal = 1'b1;
    endcase
    alu_zero = (alu_res == '0);
  end

  // Shift working value: loaded at accept, advanced one step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q      <= '0;
      rem_q       <= '0;
      dir_right_q <= 1'b0;
      arith_q     <= 1'b0;
    end else if (accept && start_run) begin
      work_q      <= a;
      rem_q       <= shamt;
      dir_right_q <= (op != OP_SLL);
      arith_q     <= (op == OP_SRA);
    end else if ((state_q == ST_RUN) && !flush) begin
      work_q <= step_out;
      rem_q  <= rem_q - SHAMT_W'(step_amt);
    end
  end

  // Result and flags: captured on completion, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept && !start_run) begin
      result_q   <= alu_res;
      carry_q    <= alu_carry;
      overflow_q <= alu_ovf;
      zero_q     <= alu_zero;
      illegal_q  <= alu_illegal;
    end else if ((state_q == ST_RUN) && last_step && !flush) begin
      result_q   <= step_out;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= (step_out == '0);
      illegal_q  <= 1'b0;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=64, SHIFT_STEP=8): a transaction-level
// reference model plus directed vectors with hand-computed expectations.
module tb_alu_mc;

  localparam int XLEN = 64;
  localparam int STEP = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      op = 4'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            carry, overflow, zero, illegal;

  int checks = 0;
  int errors = 0;

  alu_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what an op produces and how many cycles from accept to out_valid.
  function automatic void model_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                                   output logic [63:0] r, output logic c, output logic v,
                                   output logic z, output logic il, output int lat);
    int s;
    logic [64:0] u;
    logic signed [65:0] sx, sy, st;
    s  = int'(y[5:0]);
    r  = '0; c = 1'b0; v = 1'b0; il = 1'b0; lat = 1;
    sx = {{2{x[63]}}, x};
    sy = {{2{y[63]}}, y};
    st = '0;
    u  = '0;
    case (o)
      4'd0: begin
        u = {1'b0, x} + {1'b0, y}; r = u[63:0]; c = u[64];
        st = sx + sy; v = (st != {{2{r[63]}}, r});
      end
      4'd1: begin
        r = x - y; c = (x >= y);
        st = sx - sy; v = (st != {{2{r[63]}}, r});
      end
      4'd2: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd3: r = (x < y) ? 64'd1 : 64'd0;
      4'd4: r = x & y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7: r = x << s;
      4'd8: r = x >> s;
      4'd9: r = $signed(x) >>> s;
      default: il = 1'b1;
    endcase
    if ((o inside {4'd7, 4'd8, 4'd9}) && (s > 0)) lat = 1 + (s + STEP - 1) / STEP;
    z = (r == '0);
  endfunction

  // Model state: a presented result, or a countdown to one.
  bit          m_valid = 1'b0;
  int          m_wait = 0;
  logic [63:0] m_res = '0, p_res = '0;
  logic        m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_il = 1'b0;
  logic        p_c = 1'b0, p_v = 1'b0, p_z = 1'b0, p_il = 1'b0;
  bit          m_rdy, m_acc;
  logic [63:0] t_r;
  logic        t_c, t_v, t_z, t_il;
  int          t_lat;

  function automatic bit m_ready();
    return ((m_wait == 0) && !m_valid) || (m_valid && out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_wait = 0; m_res = '0;
      m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_il = 1'b0;
    end else begin
      m_rdy = m_ready();
      m_acc = in_valid && m_rdy && !flush;
      if (flush) begin
        m_valid = 1'b0; m_wait = 0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            m_valid = 1'b1; m_res = p_res;
            m_c = p_c; m_v = p_v; m_z = p_z; m_il = p_il;
          end
        end
        if (m_acc) begin
          model_op(op, a, b, t_r, t_c, t_v, t_z, t_il, t_lat);
          if (t_lat == 1) begin
            m_valid = 1'b1; m_res = t_r;
            m_c = t_c; m_v = t_v; m_z = t_z; m_il = t_il;
          end else begin
            m_wait = t_lat - 1; p_res = t_r;
            p_c = t_c; p_v = t_v; p_z = t_z; p_il = t_il;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, mid-way between edges.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, m_ready());
      if (m_valid) begin
        chk("result", result, m_res);
        chk("carry", carry, m_c);
        chk("overflow", overflow, m_v);
        chk("zero", zero, m_z);
        chk("illegal", illegal, m_il);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~x; b = ~y;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", in_ready, 0);
      tick();
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    issue(o, x, y);
    wait_out(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, result, exp_res);
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] held;
    logic [63:0] mr;
    logic        mc, mv, mz, mil;
    int          ml;

    // Pin the model with hand-computed values.
    model_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mr, mc, mv, mz, mil, ml);
    chk("model_add_res", mr, 64'd0);
    chk("model_add_c", mc, 1);
    chk("model_add_z", mz, 1);
    model_op(4'd1, 64'h8000_0000_0000_0000, 64'd1, mr, mc, mv, mz, mil, ml);
    chk("model_sub_res", mr, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("model_sub_v", mv, 1);
    model_op(4'd9, 64'h8000_0000_0000_0000, 64'd20, mr, mc, mv, mz, mil, ml);
    chk("model_sra_res", mr, 64'hFFFF_F800_0000_0000);
    chk("model_sra_lat", ml, 4);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, overflow, zero, illegal}, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // ADD wrap to zero.
    run_op("add_wrap", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    chk("add_wrap_flags", {carry, overflow, zero, illegal}, 4'b1010);
    tick();

    // SUB signed overflow, no borrow.
    run_op("sub_ovf", 4'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    chk("sub_ovf_flags", {carry, overflow, zero, illegal}, 4'b1100);
    tick();

    run_op("slt", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    run_op("sltu", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    chk("sltu_flags", {carry, overflow, zero, illegal}, 4'b0010);
    tick();

    // Multi-cycle shifts.
    run_op("sra20", 4'd9, 64'h8000_0000_0000_0000, 64'd20, 64'hFFFF_F800_0000_0000, 4);
    tick();
    run_op("sll63", 4'd7, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 9);
    chk("sll63_flags", {carry, overflow, zero, illegal}, 4'b0000);
    tick();

    // Directed table, mostly back-to-back.
    vecs.push_back('{4'd8, 64'hF000_0000_0000_0000, 64'd9, 64'h0078_0000_0000_0000, 3});
    vecs.push_back('{4'd8, 64'h100, 64'd8, 64'd1, 2});
    vecs.push_back('{4'd7, 64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{4'd7, 64'd1, 64'd67, 64'd8, 2});
    vecs.push_back('{4'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{4'd4, 64'hF0F0, 64'h0FF0, 64'h00F0, 1});
    vecs.push_back('{4'd5, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1});
    vecs.push_back('{4'd6, 64'hF0F0, 64'h0FF0, 64'hFF00, 1});
    vecs.push_back('{4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{4'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
    vecs.push_back('{4'd10, 64'd3, 64'd4, 64'd0, 1});
    vecs.push_back('{4'd9, 64'h4000_0000_0000_0000, 64'd62, 64'd1, 9});
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].lat);
    end
    tick();

    // Consumer stall, then back-to-back accept in DONE.
    out_ready = 1'b0;
    issue(4'd6, 64'h1234, 64'h00FF);
    held = result;
    chk("stall_first", result, 64'h12CB);
    repeat (3) begin
      tick();
      chk("stall_hold", result, held);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    op = 4'd0; a = 64'd2; b = 64'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", result, 64'd5);
    tick();

    // Flush mid-shift; the request offered in the flush cycle is dropped.
    issue(4'd7, 64'd1, 64'd63);
    tick();
    tick();
    flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 64'd1; b = 64'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_run_valid", out_valid, 0);
    chk("flush_run_ready", in_ready, 1);
    repeat (10) tick();

    // Flush in DONE while a new request is offered.
    out_ready = 1'b0;
    issue(4'd0, 64'd4, 64'd4);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 4'd0; a = 64'd9; b = 64'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_done_valid", out_valid, 0);
    tick();
    chk("flush_done_idle", out_valid, 0);

    // Illegal opcode.
    run_op("ill15", 4'd15, 64'h55, 64'hAA, 64'd0, 1);
    chk("ill15_flags", {carry, overflow, zero, illegal}, 4'b0011);
    tick();

    // Asynchronous reset mid-RUN.
    run_op("pre_rst", 4'd0, 64'd7, 64'd8, 64'd15, 1);
    tick();
    issue(4'd9, 64'hFF00_0000_0000_0000, 64'd40);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_flags", {carry, overflow, zero, illegal}, 0);
    #20;
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", in_ready, 1);
    repeat (8) tick();
    run_op("post_rst", 4'd0, 64'd2, 64'd3, 64'd5, 1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width (32 or 64).
REQ-002 SHALL have parameter SHIFT_STEP, default 8, max shift bits per cycle (power of two, 1..XLEN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept; transfer when in_valid & in_ready.
REQ-007 SHALL have port op  input  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10-15 illegal.
REQ-008 SHALL have ports a, b  input  XLEN  operands; shift amount = b[log2(XLEN)-1:0].
REQ-009 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-012 SHALL have ports result  output  XLEN; carry, overflow, zero, illegal  output  1 each.

Function
REQ-013 States: IDLE, RUN, DONE; in_ready = (IDLE) or (DONE and out_ready), combinational.
REQ-014 Accept in IDLE/DONE: non-shift op or shift amount 0 -> DONE next cycle (latency 1); shift amount s>0 -> RUN.
REQ-015 RUN: each cycle shifts working value by min(SHIFT_STEP, remaining); remaining reaching 0 -> DONE; shift latency = 1 + ceil(s/SHIFT_STEP).
REQ-016 in_ready SHALL be 0 throughout RUN; operands captured at accept, later input changes ignored.
REQ-017 DONE: out_valid=1; result and flags held stable until out_ready; out_ready with no new accept -> IDLE.
REQ-018 DONE with out_ready and in_valid same cycle: new op accepted (back-to-back, zero bubble).
REQ-019 ADD/SUB: XLEN-bit wrap; SUB computed as a + ~b + 1; carry = carry-out of MSB (SUB: 1 = no borrow); overflow = signed overflow.
REQ-020 SLT/SLTU: result = {XLEN-1 zeros, signed/unsigned a<b}.
REQ-021 SRA SHALL replicate a[XLEN-1]; SLL/SRL fill zeros.
REQ-022 carry and overflow SHALL be 0 for all ops except ADD/SUB; zero = (result == 0) for every op.
REQ-023 Illegal op: accepted, latency 1, result 0, zero=1, illegal=1; illegal=0 otherwise.
REQ-024 flush has priority over all events: next state IDLE, out_valid 0 next cycle, in_valid in flush cycle not accepted, in-flight result discarded.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, out_valid=0, result=0, carry=0, overflow=0, zero=0, illegal=0, independent of clk.
REQ-026 After rst_n rises, in_ready SHALL be 1; reset mid-RUN discards operation with no out_valid pulse.

Structure
REQ-027 Shared package alu_pkg SHALL hold the opcode enumeration and the state enumeration.
REQ-028 One sub-module alu_shift_step SHALL implement a combinational single-step shift (value, amount<=SHIFT_STEP, dir, arith); flags/arith logic SHALL stay in alu_mc.
REQ-029 Parameter legality (SHIFT_STEP power of two, <= XLEN) SHALL be checked at elaboration.

Verification (XLEN=64, SHIFT_STEP=8)
REQ-030 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0, zero=1, carry=1, overflow=0, out_valid 1 cycle after accept.
REQ-031 SUB a=0x8000_0000_0000_0000, b=1 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1; SLT(-1,1)=1, SLTU(-1,1)=0.
REQ-032 SRA a=0x8000_0000_0000_0000, b=20 -> 0xFFFF_F800_0000_0000, out_valid exactly 4 cycles after accept, in_ready 0 in RUN; SLL b=63 -> latency 9.
REQ-033 out_ready low 3 cycles in DONE -> result stable, in_ready 0; then out_ready=1 with in_valid (ADD 2+3) -> accepted same cycle, 5 presented next cycle.
REQ-034 flush 3 cycles into SLL by 63 -> no out_valid, in_ready 1 next cycle; op=15 -> result 0, illegal=1, zero=1.
REQ-035 rst_n low mid-RUN -> out_valid and result 0 without a clock edge; after release first op completes normally.
